uart_alu_if: RTL and testbench
==============================

# uart_alu_if

Command interface between the UART receiver and UART transmitter. It collects three consecutive received bytes (operand A, operand B, opcode) and evaluates the ALU operation internally. It hands the one-byte result to the transmitter with a start pulse, then waits for the transmitter's done pulse before accepting a new command.

## Interface
- NB_DATA, 8, width of received bytes, operands and result
- NB_OP, 6, number of opcode bits taken from the LSBs of the opcode byte
- i_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  synchronous, active-low reset
- i_rx_data  in  NB_DATA  byte from UART receiver; valid only when i_rx_valid=1
- i_rx_valid  in  1  one-cycle pulse from receiver, byte available
- i_tx_done  in  1  one-cycle pulse from transmitter, frame fully sent
- o_tx_data  out  NB_DATA  result byte to transmitter; registered, held stable until next result
- o_tx_start  out  1  one-cycle pulse, transmitter starts sending o_tx_data
- o_busy  out  1  high while waiting for i_tx_done
- o_op_error  out  1  high when the last result came from an unsupported opcode

## Operation
- States: GET_A, GET_B, GET_OP, WAIT_TX.
- Reset (i_rst=0 at a rising edge) has priority over everything:
  - state forced to GET_A; A, B, o_tx_data all 0
  - o_tx_start=0, o_busy=0, o_op_error=0
  - reset mid-command discards any captured bytes
- GET_A: on i_rx_valid, capture A and clear o_op_error; go to GET_B.
- GET_B: on i_rx_valid, capture B; go to GET_OP.
- GET_OP: on i_rx_valid, decode i_rx_data[NB_OP-1:0] against the captured A/B. On the same edge:
  - register the result into o_tx_data
  - set o_op_error (1 if the opcode is unsupported, else 0)
  - assert o_tx_start and o_busy
  - go to WAIT_TX
- Opcode byte bits above NB_OP are ignored.
- WAIT_TX:
  - o_tx_start lasts exactly one cycle; o_busy stays 1.
  - On i_tx_done, o_busy drops and the state returns to GET_A on that edge.
  - i_rx_valid pulses in WAIT_TX are dropped; they are not queued.
- i_tx_done outside WAIT_TX is ignored.
- Opcodes (6-bit) and results:
  - 100000 ADD: A+B mod 2^NB_DATA
  - 100010 SUB: A−B mod 2^NB_DATA
  - 100100 AND
  - 100101 OR
  - 100110 XOR
  - 100111 NOR
  - 000011 SRA: A arithmetic right shift by B as unsigned; B ≥ NB_DATA gives all bits = A's MSB
  - 000010 SRL: A logical right shift by B as unsigned; B ≥ NB_DATA gives 0
  - any other opcode: result 0, o_op_error=1
- No carry or overflow flags are produced.

## Timing
- Capture edge: the rising edge where i_rx_valid=1 in the matching state.
- Latency: o_tx_start and the new o_tx_data are visible in the cycle after the opcode capture edge (1 cycle).
- o_tx_data and o_op_error hold until the next opcode capture or reset.
- i_tx_done is honoured in any WAIT_TX cycle, including the cycle in which o_tx_start=1.
- i_rx_valid and i_tx_done in the same cycle while in WAIT_TX: return to GET_A; the rx byte is dropped.
- Minimum command-to-command spacing: the next A is accepted from the cycle after the i_tx_done edge.
- Consecutive i_rx_valid pulses on back-to-back cycles are each accepted; there is no minimum gap.

## Test plan
- Reset, then bytes 0x05, 0x03, 0x20 -> one cycle later o_tx_data=0x08, o_tx_start=1 for exactly one cycle, o_busy=1, o_op_error=0; i_tx_done pulse -> o_busy=0.
- SUB: bytes 0x03, 0x05, 0x22 -> o_tx_data=0xFE. NOR: 0x0F, 0xF0, 0x27 -> 0x00. Opcode byte 0xE0 (upper bits set, LSBs = ADD) with 0x01, 0x01 -> 0x02.
- Shifts:
  - SRA 0x80 by 0x02 (op 0x03) -> 0xE0
  - SRA 0x80 by 0x09 -> 0xFF
  - SRL 0x80 by 0x09 (op 0x02) -> 0x00
  - SRL 0xF0 by 0x04 -> 0x0F
- Bad opcode: 0x11, 0x22, 0x3F -> o_tx_data=0x00, o_op_error=1; next command's A byte clears o_op_error to 0.
- Drop in WAIT_TX: after a command, send rx byte 0x77 before i_tx_done, then i_tx_done, then 0x02, 0x03, 0x20 -> result 0x05 (0x77 not used).
- Reset mid-command: send 0x10, 0x20, pull i_rst low 1 cycle, then 0x01, 0x01, 0x20 -> result 0x02; o_tx_start never pulses before the third post-reset byte.

Source files
------------

// File: rtl/uart_alu_if.sv
// uart_alu_if: collects A, B and opcode bytes from the UART receiver, evaluates the ALU op and hands the result to the transmitter.
module uart_alu_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_op_error
);
  typedef enum logic [1:0] {GET_A, GET_B, GET_OP, WAIT_TX} state_t;
  state_t state;
  logic [NB_DATA-1:0] a, b, res, sra, srl;
  logic [NB_OP-1:0] op;
  logic bad_op;
  // Shift amounts of NB_DATA or more saturate to a full sign fill or zero.
  assign op  = i_rx_data[NB_OP-1:0];
  assign sra = b >= NB_DATA'(NB_DATA) ? {NB_DATA{a[NB_DATA-1]}} : NB_DATA'($signed(a) >>> b);
  assign srl = b >= NB_DATA'(NB_DATA) ? '0 : a >> b;
  always_comb begin
    res    = '0;
    bad_op = 1'b0;
    case (op)
      6'b100000: res = a + b;
      6'b100010: res = a - b;
      6'b100100: res = a & b;
      6'b100101: res = a | b;
      6'b100110: res = a ^ b;
      6'b100111: res = ~(a | b);
      6'b000011: res = sra;
      6'b000010: res = srl;
      default:   bad_op = 1'b1;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state      <= GET_A;
      a          <= '0;
      b          <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_op_error <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      case (state)
        GET_A: if (i_rx_valid) begin
          a          <= i_rx_data;
          o_op_error <= 1'b0;
          state      <= GET_B;
        end
        GET_B: if (i_rx_valid) begin
          b     <= i_rx_data;
          state <= GET_OP;
        end
        GET_OP: if (i_rx_valid) begin
          o_tx_data  <= res;
          o_op_error <= bad_op;
          o_tx_start <= 1'b1;
          o_busy     <= 1'b1;
          state      <= WAIT_TX;
        end
        WAIT_TX: if (i_tx_done) begin
          o_busy <= 1'b0;
          state  <= GET_A;
        end
        default: state <= GET_A;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_alu_if.sv
// tb_uart_alu_if: directed vector table plus hand sequences for handshake and reset corners.
module tb_uart_alu_if;
  logic i_clk = 1'b0, i_rst = 1'b0, i_rx_valid = 1'b0, i_tx_done = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic [7:0] o_tx_data;
  logic o_tx_start, o_busy, o_op_error;
  int n_run = 0, n_fail = 0;
  typedef struct {
    logic [7:0] a, b, op, res;
    logic       err;
    string      name;
  } vec_t;
  vec_t vecs[14];
  always #5 i_clk = ~i_clk;
  uart_alu_if dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .i_tx_done(i_tx_done), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .o_busy(o_busy), .o_op_error(o_op_error)
  );
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] d);
    i_rx_data  = d;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask
  task automatic pulse_done();
    i_tx_done = 1'b1;
    @(negedge i_clk);
    i_tx_done = 1'b0;
  endtask
  task automatic run_cmd(input logic [7:0] a, b, op, res, input logic err, input string name);
    send(a);
    send(b);
    send(op);
    check({name, " start"}, {7'd0, o_tx_start}, 8'd1);
    check({name, " data"}, o_tx_data, res);
    check({name, " busy"}, {7'd0, o_busy}, 8'd1);
    check({name, " err"}, {7'd0, o_op_error}, {7'd0, err});
    @(negedge i_clk);
    check({name, " start1"}, {7'd0, o_tx_start}, 8'd0);
    check({name, " busy1"}, {7'd0, o_busy}, 8'd1);
    pulse_done();
    check({name, " idle"}, {7'd0, o_busy}, 8'd0);
    check({name, " hold"}, o_tx_data, res);
  endtask
  initial begin
    vecs[0]  = '{8'h05, 8'h03, 8'h20, 8'h08, 1'b0, "add"};
    vecs[1]  = '{8'h03, 8'h05, 8'h22, 8'hFE, 1'b0, "sub"};
    vecs[2]  = '{8'h0F, 8'hF0, 8'h27, 8'h00, 1'b0, "nor"};
    vecs[3]  = '{8'h01, 8'h01, 8'hE0, 8'h02, 1'b0, "add_hi"};
    vecs[4]  = '{8'h80, 8'h02, 8'h03, 8'hE0, 1'b0, "sra2"};
    vecs[5]  = '{8'h80, 8'h09, 8'h03, 8'hFF, 1'b0, "sra9"};
    vecs[6]  = '{8'h80, 8'h09, 8'h02, 8'h00, 1'b0, "srl9"};
    vecs[7]  = '{8'hF0, 8'h04, 8'h02, 8'h0F, 1'b0, "srl4"};
    vecs[8]  = '{8'h0C, 8'h0A, 8'h24, 8'h08, 1'b0, "and"};
    vecs[9]  = '{8'h0C, 8'h0A, 8'h25, 8'h0E, 1'b0, "or"};
    vecs[10] = '{8'h0C, 8'h0A, 8'h26, 8'h06, 1'b0, "xor"};
    vecs[11] = '{8'h7F, 8'h08, 8'h02, 8'h00, 1'b0, "srl8"};
    vecs[12] = '{8'h81, 8'h07, 8'h03, 8'hFF, 1'b0, "sra7"};
    vecs[13] = '{8'h11, 8'h22, 8'h3F, 8'h00, 1'b1, "badop"};
    @(negedge i_clk);
    @(negedge i_clk);
    check("rst data", o_tx_data, 8'h00);
    check("rst start", {7'd0, o_tx_start}, 8'd0);
    check("rst busy", {7'd0, o_busy}, 8'd0);
    check("rst err", {7'd0, o_op_error}, 8'd0);
    i_rst = 1'b1;
    for (int i = 0; i < 14; i++)
      run_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].err, vecs[i].name);
    // error flag is still set from the bad opcode until the next A byte
    check("err held", {7'd0, o_op_error}, 8'd1);
    send(8'h05);
    check("err clr", {7'd0, o_op_error}, 8'd0);
    send(8'h03);
    send(8'h20);
    check("clr data", o_tx_data, 8'h08);
    pulse_done();
    send(8'h05);
    send(8'h03);
    send(8'h20);
    @(negedge i_clk);
    send(8'h77);
    check("drop busy", {7'd0, o_busy}, 8'd1);
    check("drop start", {7'd0, o_tx_start}, 8'd0);
    pulse_done();
    run_cmd(8'h02, 8'h03, 8'h20, 8'h05, 1'b0, "after_drop");
    send(8'h01);
    send(8'h02);
    send(8'h20);
    check("early start", {7'd0, o_tx_start}, 8'd1);
    pulse_done();
    check("early idle", {7'd0, o_busy}, 8'd0);
    run_cmd(8'h04, 8'h05, 8'h20, 8'h09, 1'b0, "after_early");
    send(8'h06);
    send(8'h06);
    send(8'h20);
    i_rx_data  = 8'h55;
    i_rx_valid = 1'b1;
    i_tx_done  = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
    i_tx_done  = 1'b0;
    check("both idle", {7'd0, o_busy}, 8'd0);
    run_cmd(8'h04, 8'h04, 8'h20, 8'h08, 1'b0, "after_both");
    send(8'h10);
    send(8'h20);
    i_rst = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    check("mid rst data", o_tx_data, 8'h00);
    check("mid rst busy", {7'd0, o_busy}, 8'd0);
    send(8'h01);
    check("mid rst s1", {7'd0, o_tx_start}, 8'd0);
    send(8'h01);
    check("mid rst s2", {7'd0, o_tx_start}, 8'd0);
    send(8'h20);
    check("mid rst start", {7'd0, o_tx_start}, 8'd1);
    check("mid rst res", o_tx_data, 8'h02);
    pulse_done();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
